// File: rtl/excp_commit_pkg.sv
// Shared definitions for the exception commit block: exception codes, CSR numbers, FSM states.
// Optional BADV recording is enabled by defining EXCP_COMMIT_BADV_EN.
package excp_commit_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [8:0] ESUBCODE_NONE = 9'h000;

    localparam logic [13:0] CSR_CRMD   = 14'h0000;
    localparam logic [13:0] CSR_PRMD   = 14'h0001;
    localparam logic [13:0] CSR_ECFG   = 14'h0004;
    localparam logic [13:0] CSR_ESTAT  = 14'h0005;
    localparam logic [13:0] CSR_ERA    = 14'h0006;
    localparam logic [13:0] CSR_BADV   = 14'h0007;
    localparam logic [13:0] CSR_EENTRY = 14'h000C;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01
    } state_e;

endpackage

// File: rtl/excp_commit_if.sv
// Writeback/CSR/fetch-redirect signal bundle for excp_commit; slave is the commit block's view.
// BADV signals exist only when EXCP_COMMIT_BADV_EN is defined.
interface excp_commit_if;
    logic        ws_valid;
    logic [31:0] ws_pc;
    logic        ws_adef;
    logic        ws_ine;
    logic        ws_sys;
    logic        ws_brk;
    logic        ws_ale;
    logic        ws_ertn;
    logic        ws_csr_we;
    logic [13:0] ws_csr_num;
    logic [31:0] ws_csr_wdata;
    logic [31:0] ws_vaddr;
    logic        has_int;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        csr_wr_en;
    logic [13:0] wr_addr;
    logic [31:0] wr_data;
    logic        excp_flush;
    logic        ertn_flush;
    logic [31:0] era_in;
    logic [5:0]  ecode_in;
    logic [8:0]  esubcode_in;
`ifdef EXCP_COMMIT_BADV_EN
    logic [31:0] badv_out;
    logic        badv_we;
`endif
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        pipe_flush;

    modport master (
        output ws_valid, ws_pc, ws_adef, ws_ine, ws_sys, ws_brk, ws_ale, ws_ertn,
        output ws_csr_we, ws_csr_num, ws_csr_wdata, ws_vaddr,
        output has_int, csr_eentry, csr_era, redirect_ready,
        input  csr_wr_en, wr_addr, wr_data, excp_flush, ertn_flush,
        input  era_in, ecode_in, esubcode_in,
`ifdef EXCP_COMMIT_BADV_EN
        input  badv_out, badv_we,
`endif
        input  redirect_valid, redirect_pc, pipe_flush
    );

    modport slave (
        input  ws_valid, ws_pc, ws_adef, ws_ine, ws_sys, ws_brk, ws_ale, ws_ertn,
        input  ws_csr_we, ws_csr_num, ws_csr_wdata, ws_vaddr,
        input  has_int, csr_eentry, csr_era, redirect_ready,
        output csr_wr_en, wr_addr, wr_data, excp_flush, ertn_flush,
        output era_in, ecode_in, esubcode_in,
`ifdef EXCP_COMMIT_BADV_EN
        output badv_out, badv_we,
`endif
        output redirect_valid, redirect_pc, pipe_flush
    );
endinterface

// File: rtl/excp_commit_prio_enc.sv
// Exception cause priority encoder: INT > ADEF > INE > SYS > BRK > ALE.
// badv_sel marks causes that carry a faulting address (ADEF, ALE).
module excp_prio_enc
    import excp_commit_pkg::*;
(
    input  logic       has_int,
    input  logic       adef,
    input  logic       ine,
    input  logic       sys,
    input  logic       brk,
    input  logic       ale,
    output logic       hit,
    output logic [5:0] ecode,
    output logic [8:0] esubcode,
    output logic       badv_sel
);

    always_comb begin
        hit      = 1'b1;
        ecode    = ECODE_INT;
        esubcode = ESUBCODE_NONE;
        badv_sel = 1'b0;
        if (has_int) begin
            ecode = ECODE_INT;
        end else if (adef) begin
            ecode    = ECODE_ADEF;
            badv_sel = 1'b1;
        end else if (ine) begin
            ecode = ECODE_INE;
        end else if (sys) begin
            ecode = ECODE_SYS;
        end else if (brk) begin
            ecode = ECODE_BRK;
        end else if (ale) begin
            ecode    = ECODE_ALE;
            badv_sel = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/excp_commit.sv
// Writeback-stage exception/ERTN commit: pulses flush, records the cause and redirects fetch.
// Define EXCP_COMMIT_BADV_EN to add the bad-address record outputs.
module excp_commit
    import excp_commit_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    excp_commit_if.slave       bus
);

    state_e      state_q, state_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        hit;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        badv_sel;
    logic        take;

    excp_prio_enc u_prio_enc (
        .has_int  (bus.has_int),
        .adef     (bus.ws_adef),
        .ine      (bus.ws_ine),
        .sys      (bus.ws_sys),
        .brk      (bus.ws_brk),
        .ale      (bus.ws_ale),
        .hit      (hit),
        .ecode    (ecode),
        .esubcode (esubcode),
        .badv_sel (badv_sel)
    );

    // Pulses are gated by resetn so nothing fires in the reset cycle itself.
    always_comb begin
        take          = resetn & bus.ws_valid & (state_q == ST_IDLE);
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;

        bus.excp_flush     = take & hit;
        bus.ertn_flush     = take & ~hit & bus.ws_ertn;
        bus.csr_wr_en      = take & ~hit & ~bus.ws_ertn & bus.ws_csr_we;
        bus.wr_addr        = bus.ws_csr_num;
        bus.wr_data        = bus.ws_csr_wdata;
        bus.era_in         = bus.ws_pc;
        bus.ecode_in       = ecode;
        bus.esubcode_in    = esubcode;
        bus.redirect_valid = resetn & (state_q == ST_REDIRECT);
        bus.pipe_flush     = resetn & (state_q == ST_REDIRECT);
        bus.redirect_pc    = redirect_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.excp_flush) begin
                    state_d       = ST_REDIRECT;
                    redirect_pc_d = bus.csr_eentry;
                end else if (bus.ertn_flush) begin
                    state_d       = ST_REDIRECT;
                    redirect_pc_d = bus.csr_era;
                end
            end
            ST_REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef EXCP_COMMIT_BADV_EN
    always_comb begin
        bus.badv_we  = bus.excp_flush & badv_sel;
        bus.badv_out = bus.ws_vaddr;
    end
`else
    logic unused_badv;
    assign unused_badv = &{1'b0, badv_sel, bus.ws_vaddr};
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

endmodule
